sync_step_engine: RTL

SYNC_STEP_ENGINE -- requirements
Module: sync_step_engine

---
 rtl/sync_model_pkg.sv | 24 ++
 rtl/sync_state_bit.sv | 24 ++
 rtl/sync_step_engine.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/sync_model_pkg.sv
// Shared constants and elaboration-time width helpers for the sync step engine.
package sync_model_pkg;

    localparam int MODE_INTERLEAVE = 0;
    localparam int MODE_CONCURRENT = 1;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Interleaved index must also encode "idle", hence N_SIG+1 distinct codes.
    function automatic int ena_width(input int n_sig);
        return (clog2(n_sig + 1) < 1) ? 1 : clog2(n_sig + 1);
    endfunction

endpackage

// File: rtl/sync_state_bit.sv
// One signal register: loads its reset value, otherwise toggles when enabled.
// Toggle is visible one cycle after en; no backpressure.
module sync_state_bit #(
    parameter logic INIT_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= INIT_VAL;
        end else if (en) begin
            r_q <= ~r_q;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/sync_step_engine.sv
// Step engine: fires requested excited signals, one cycle latency, no backpressure.
// Optional hazard tracking is built when SYNC_STEP_HAZARD_EN is defined.
module sync_step_engine
    import sync_model_pkg::*;
#(
    parameter int               N_SIG = 8,
    parameter int               N_IN  = 2,
    parameter logic [N_SIG-1:0] INIT  = '0,
    parameter int               MODE  = MODE_INTERLEAVE,
    parameter int               CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ena_width(N_SIG)-1:0]   ena,
    input  logic [N_SIG-1:0]              ena_mask,
    input  logic [N_SIG-1:0]              nxt,
    output logic [N_SIG-1:0]              state,
    output logic [N_SIG-1:0]              excited,
    output logic                          stable,
    output logic                          fired,
    output logic                          illegal,
    output logic [CNT_W-1:0]              fire_cnt,
    output logic                          hazard,
    output logic [N_SIG-1:0]              hazard_vec
);

    localparam int EW = ena_width(N_SIG);
    localparam int PW = clog2(N_SIG + 1);
    localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
    localparam logic [SW-1:0] CNT_MAX = {{(SW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [N_SIG-1:0] w_state;
    logic [N_SIG-1:0] w_excited;
    logic [N_SIG-1:0] w_gate_mask;
    logic [N_SIG-1:0] w_req;
    logic [N_SIG-1:0] w_fv;
    logic [PW-1:0]    w_pop;
    logic [SW-1:0]    w_sum;
    logic             r_fired;
    logic             r_illegal;
    logic [CNT_W-1:0] r_fire_cnt;
    logic             w_unused_ok;

    // An input's next value is always its complement, so inputs are always excited.
    always_comb begin
        w_excited   = '0;
        w_gate_mask = '0;
        for (int i = 0; i < N_SIG; i++) begin
            if (i < N_IN) begin
                w_excited[i] = 1'b1;
            end else begin
                w_excited[i]   = nxt[i] ^ w_state[i];
                w_gate_mask[i] = 1'b1;
            end
        end
    end

    generate
        if (MODE == MODE_CONCURRENT) begin : g_conc
            assign w_req = ena_mask;
        end else begin : g_intl
            always_comb begin
                w_req = '0;
                for (int i = 0; i < N_SIG; i++) begin
                    if (ena == EW'(i)) begin
                        w_req[i] = 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign w_fv = w_req & w_excited;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_SIG; i++) begin
            w_pop = w_pop + PW'(w_fv[i]);
        end
    end

    assign w_sum = SW'(r_fire_cnt) + SW'(w_pop);

    generate
        for (genvar g = 0; g < N_SIG; g++) begin : g_bit
            sync_state_bit #(
                .INIT_VAL (INIT[g])
            ) u_bit (
                .clk   (clk),
                .reset (reset),
                .en    (w_fv[g]),
                .q     (w_state[g])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fired    <= 1'b0;
            r_illegal  <= 1'b0;
            r_fire_cnt <= '0;
        end else begin
            r_fired    <= |w_fv;
            r_illegal  <= |(w_req & ~w_excited);
            r_fire_cnt <= (w_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : w_sum[CNT_W-1:0];
        end
    end

`ifdef SYNC_STEP_HAZARD_EN
    logic [N_SIG-1:0] r_exc_q;
    logic [N_SIG-1:0] r_fv_q;
    logic [N_SIG-1:0] r_hazard_vec;

    // A gate that was excited, did not fire, and is no longer excited lost its excitation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exc_q      <= '0;
            r_fv_q       <= '0;
            r_hazard_vec <= '0;
        end else begin
            r_exc_q      <= w_excited;
            r_fv_q       <= w_fv;
            r_hazard_vec <= r_hazard_vec | (r_exc_q & ~r_fv_q & ~w_excited & w_gate_mask);
        end
    end

    assign hazard     = |r_hazard_vec;
    assign hazard_vec = r_hazard_vec;
`else
    assign hazard     = 1'b0;
    assign hazard_vec = '0;
`endif

    assign w_unused_ok = ^{ena, ena_mask, nxt};

    assign state    = w_state;
    assign excited  = w_excited;
    assign stable   = ~|(w_excited & w_gate_mask);
    assign fired    = r_fired;
    assign illegal  = r_illegal;
    assign fire_cnt = r_fire_cnt;

endmodule
